// File: rtl/avalon_pkg.sv
// Shared types and constants for the avalon_sink receive path.
package avalon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int BEAT_CNT_W = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head data reads 0 while empty.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign count     = count_q;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/avalon_sink.sv
// Ready-latency-1 Avalon-ST burst sink feeding a local FIFO.
// Optional payload sequence checker enabled by defining AVALON_SINK_CHECK_EN.
module avalon_sink
    import avalon_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 4,
    parameter int N_BEATS = 3
`ifdef AVALON_SINK_CHECK_EN
    ,
    parameter int FIRST_VAL = 4
`endif
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   valid,
    input  logic [DATA_W-1:0]      data,
    output logic                   ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    input  logic                   out_ready,
    output logic [BEAT_CNT_W-1:0]  beat_cnt,
    output logic                   done,
    output logic                   protocol_err,
    output logic                   seq_err
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t                 state_q, state_d;
    logic                   ready_q;
    logic [BEAT_CNT_W-1:0]  grant_cnt_q, grant_cnt_d;
    logic [BEAT_CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic                   done_q, done_d;
    logic                   perr_q, perr_d;
    logic                   seq_err_q, seq_err_d;
    logic                   accept, pop, seq_mismatch;
    logic                   fifo_empty, fifo_full;
    logic [CNT_W-1:0]       fifo_count;

    assign accept = valid && ready_q;
    assign pop    = out_valid && out_ready;

    // Same-cycle pops are not credited, so a granted beat always finds room
    assign ready = (state_q == ST_RECV)
                && (grant_cnt_q < BEAT_CNT_W'(N_BEATS))
                && ((fifo_count + CNT_W'(ready_q)) < CNT_W'(DEPTH));

`ifdef AVALON_SINK_CHECK_EN
    assign seq_mismatch = accept && (data != (DATA_W'(FIRST_VAL) + DATA_W'(beat_cnt_q)));
`else
    assign seq_mismatch = 1'b0;
`endif

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (accept),
        .push_data (data),
        .pop       (pop),
        .head_data (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign out_valid    = !fifo_empty;
    assign beat_cnt     = beat_cnt_q;
    assign done         = done_q;
    assign protocol_err = perr_q;
    assign seq_err      = seq_err_q;

    always_comb begin
        state_d     = state_q;
        grant_cnt_d = grant_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        done_d      = done_q;
        perr_d      = perr_q;
        seq_err_d   = seq_err_q;
        if (ready)          grant_cnt_d = grant_cnt_q + 1'b1;
        if (accept)         beat_cnt_d  = beat_cnt_q + 1'b1;
        if (valid && !ready_q) perr_d   = 1'b1;
        if (seq_mismatch)   seq_err_d   = 1'b1;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RECV;
                    grant_cnt_d = '0;
                    beat_cnt_d  = '0;
                    done_d      = 1'b0;
                    perr_d      = 1'b0;
                    seq_err_d   = 1'b0;
                end
            end
            ST_RECV: begin
                if (accept && (beat_cnt_q == BEAT_CNT_W'(N_BEATS - 1))) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            grant_cnt_q <= '0;
            beat_cnt_q  <= '0;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready;
            grant_cnt_q <= grant_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            done_q      <= done_d;
            perr_q      <= perr_d;
            seq_err_q   <= seq_err_d;
        end
    end

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: doc/avalon_sink.md
# avalon_sink

Avalon-ST sink that receives a fixed-length burst of beats from an upstream ready-latency-1 source (one beat per granted `ready`, delivered the cycle after the grant) and buffers it in a small FIFO. The FIFO drains to a local consumer over a ready-latency-0 valid/ready port. It sits at the receive end of the team's 8-bit streaming link and counts beats, flags protocol violations and, optionally, checks the payload sequence.

## Interface
- `DATA_W`, 8, beat width
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2
- `N_BEATS`, 3, beats per burst; 1..255
- `FIRST_VAL`, 4, expected value of the first beat (checker only)
- `clk`  in  1  rising-edge clock
- `resetn`  in  1  reset; **one clock; reset is asynchronous and active-low**
- `start`  in  1  one-cycle pulse; arms a burst
- `valid`  in  1  upstream beat present
- `data`  in  DATA_W  upstream beat payload
- `ready`  out  1  grant to upstream; a beat may arrive on the next cycle
- `out_valid`  out  1  FIFO not empty
- `out_data`  out  DATA_W  FIFO head
- `out_ready`  in  1  consumer pop; a pop occurs when `out_valid && out_ready`
- `beat_cnt`  out  8  beats accepted in the current burst
- `done`  out  1  high from burst completion until the next `start`
- `protocol_err`  out  1  sticky; valid beat with no grant
- `seq_err`  out  1  sticky; payload mismatch

## Operation
- FSM states: IDLE, RECV, DONE.
  - IDLE→RECV on `start`. This clears `beat_cnt`, `grant_cnt`, `done`, `seq_err` and `protocol_err`.
  - RECV→DONE in the cycle the N_BEATS-th beat is accepted.
  - DONE→RECV on `start`. The restart clears the same items as IDLE→RECV.
  - `start` in RECV is ignored.
- `ready_q` is `ready` registered, reset value 0.
- A beat is accepted when `valid && ready_q`. It is written to the FIFO tail and increments `beat_cnt`.
- `ready` is combinational from registered state: `state==RECV && grant_cnt<N_BEATS && (count + ready_q) < DEPTH`.
  - `count` is FIFO occupancy at the start of the cycle.
  - Same-cycle pops are not credited, so the grant rule is conservative and the FIFO can never overflow.
- `grant_cnt` increments on every cycle with `ready`=1. This prevents soliciting beats beyond N_BEATS.
- `valid && !ready_q` sets `protocol_err`; the beat is dropped. `valid` outside RECV is handled the same way.
- Push and pop in the same cycle are allowed: occupancy is unchanged.
- Pointers wrap modulo DEPTH. Occupancy is held in log2(DEPTH)+1 bits.
- The FIFO keeps draining in DONE and IDLE.
- Reset mid-burst: the FIFO is emptied and all state returns to reset values. Beats in flight are lost.
- Reset values: `ready`=0, `out_valid`=0, `out_data`=0, `beat_cnt`=0, `done`=0, `protocol_err`=0, `seq_err`=0, state IDLE.

## Timing
- `ready` can first assert in the cycle after the `start` edge.
- Input-to-output latency: a beat accepted at edge t appears on `out_valid`/`out_data` after edge t, i.e. one cycle.
- With the FIFO drained every cycle and DEPTH ≥ 2, `ready` and accepted beats alternate or stream back-to-back. For the back-to-back case, the burst completes N_BEATS+1 cycles after `start`.
- `done` rises after the edge that accepts the last beat.

## Configuration
- `AVALON_SINK_CHECK_EN` defined:
  - Beat k of a burst (k from 0) is compared with `(FIRST_VAL + k) mod 2^DATA_W`.
  - Any mismatch sets `seq_err` (sticky until the next `start` or reset).
- `AVALON_SINK_CHECK_EN` not defined:
  - The comparator is absent and `seq_err` is tied to 0.
  - All other behaviour is identical.

## Structure
- Package `avalon_pkg` holds:
  - the state encoding (IDLE/RECV/DONE localparams or typedef);
  - default `DATA_W`;
  - the beat-counter width constant (8).
- Sub-module `sync_fifo`:
  - parameters DATA_W and DEPTH;
  - push/pop inputs, empty/full flags, `count` output, head data;
  - async active-low reset.

## Test plan
- **Nominal burst.** Set defaults, pulse `start`; the source sends 4,5,6 on grants with `out_ready`=1. Required: `out_data` reads 4,5,6; `beat_cnt`=3; `done`=1; `seq_err`=0; `protocol_err`=0; `ready`=0 afterwards.
- **Backpressure.** Hold `out_ready`=0 with DEPTH=2. Required: `ready` deasserts after 2 grants and the FIFO holds 2 beats with no overflow. Release `out_ready`: the 3rd grant issues and all 3 beats come out in order.
- **Protocol violation.** Assert `valid` with data 9 in IDLE. Required: `protocol_err`=1 and the FIFO stays empty. Pulse `start`: `protocol_err` clears.
- **Sequence error.** Macro defined; the source sends 4,7,6. Required: `seq_err`=1 after the 2nd beat and `done`=1 after the 3rd. Without the macro, `seq_err` stays 0.
- **Reset mid-burst.** Drop `resetn` after 1 accepted beat. Required: all outputs at reset values immediately (asynchronous) and `out_valid`=0. A new `start` runs a clean 4,5,6 burst.
- **Restart from DONE and wrap.** Run 3 bursts back-to-back with DEPTH=4 (9 pushes). Required: pointer wrap is correct, each burst has `beat_cnt`=3, and the data order is preserved.
